debug_probe_led: RTL

Parametrised board debug probe. It selects one of `CHANNELS` probe words (register-file dump, bus taps, PC, etc.), debounces the DIP-switch controls, and drives the LEDs in one of four modes: live slice, triggered hold, change counter, or sticky change mask. It also shows the selected channel and the mode on the two seven-segment digits. It sits in the board top level between the SOPC debug outputs and the `led`/`segdisp` pins.

---
 rtl/debug_probe_led.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/debug_probe_led.sv
// debug_probe_led
//   Board debug probe. It selects one of CHANNELS probe words, debounces the
//   DIP-switch controls, and drives the LEDs in one of four modes:
//   live slice, triggered hold, change counter, or sticky change mask.
//   The effective channel and mode are also shown on two seven-segment digits.
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   probe_i   CHANNELS*DATA_W flat probe words, channel i at [i*DATA_W +: DATA_W]
//   sel_i     raw channel-select switches
//   mode_i    raw mode switches (00 LIVE, 01 HOLD, 10 COUNT, 11 MASK)
//   slice_i   raw LED_W-wide slice index used by LIVE/HOLD
//   trig_i    raw capture/clear pushbutton
//   led       registered LED drive
//   segdisp0  low hex digit of the effective select, [0]=segment a, active-high
//   segdisp1  hex digit of the effective mode
module debug_probe_led #(
   parameter int CHANNELS        = 32,
   parameter int DATA_W          = 32,
   parameter int LED_W           = 16,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SEL_W           = $clog2(CHANNELS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*DATA_W-1:0]   probe_i,
   input  logic [SEL_W-1:0]             sel_i,
   input  logic [1:0]                   mode_i,
   input  logic [1:0]                   slice_i,
   input  logic                         trig_i,
   output logic [LED_W-1:0]             led,
   output logic [0:6]                   segdisp0,
   output logic [0:6]                   segdisp1
);

   localparam int              CW      = SEL_W + 4;
   localparam int              MASK_W  = (CHANNELS < LED_W) ? CHANNELS : LED_W;
   localparam logic [15:0]     DB_LIM  = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0]     DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [SEL_W:0]  CH_LIM  = (SEL_W + 1)'(CHANNELS);

   // Hex digit to segments a..g (index 0 = a).
   function automatic logic [0:6] hex7(input logic [3:0] v);
      logic [0:6] seg;
      case (v)
         4'h0: seg = 7'b1111110;
         4'h1: seg = 7'b0110000;
         4'h2: seg = 7'b1101101;
         4'h3: seg = 7'b1111001;
         4'h4: seg = 7'b0110011;
         4'h5: seg = 7'b1011011;
         4'h6: seg = 7'b1011111;
         4'h7: seg = 7'b1110000;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1111011;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b0011111;
         4'hC: seg = 7'b1001110;
         4'hD: seg = 7'b0111101;
         4'hE: seg = 7'b1001111;
         4'hF: seg = 7'b1000111;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   // LED_W-wide slice s of a word zero-extended to 4*LED_W; bits past DATA_W read 0.
   function automatic logic [LED_W-1:0] slice_of(input logic [DATA_W-1:0] w, input logic [1:0] s);
      logic [LED_W-1:0] r;
      int idx;
      for (int b = 0; b < LED_W; b++) begin
         idx = int'(s) * LED_W + b;
         if (idx < DATA_W) r[b] = w[idx % DATA_W];
         else              r[b] = 1'b0;
      end
      return r;
   endfunction

   logic [CW-1:0]                ctrl_raw_s, ctrl_s1_r, ctrl_s2_r;
   logic [15:0]                  stab_cnt_r;
   logic                         load_s, sel_upd_s;
   logic [SEL_W-1:0]             sel_new_s, sel_eff_r, sel_idx_s;
   logic [1:0]                   mode_eff_r, slice_eff_r;
   logic                         trig_s1_r, trig_s2_r, trig_prev_r, trig_edge_s;
   logic [CHANNELS*DATA_W-1:0]   prev_all_r;
   logic [CHANNELS-1:0]          chg_s;
   logic [MASK_W-1:0]            mask_r;
   logic [DATA_W-1:0]            sel_word_s, hold_r;
   logic [LED_W-1:0]             cnt_r, mask_led_s, led_next_s;
   logic [3:0]                   sel_nib_s;

   assign ctrl_raw_s = {sel_i, mode_i, slice_i};

   // Control decode: debounce load strobe, select change, trigger edge, channel fallback.
   always_comb begin
      if ((ctrl_s1_r == ctrl_s2_r) && (stab_cnt_r == DB_LAST)) load_s = 1'b1;
      else                                                     load_s = 1'b0;
      sel_new_s   = ctrl_s2_r[CW-1 -: SEL_W];
      sel_upd_s   = load_s && (sel_new_s != sel_eff_r);
      trig_edge_s = trig_s2_r & ~trig_prev_r;
      if ({1'b0, sel_eff_r} < CH_LIM) sel_idx_s = sel_eff_r;
      else                            sel_idx_s = {SEL_W{1'b0}};
   end

   // Control synchroniser and stability counter; a differing word restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_s1_r  <= {CW{1'b0}};
         ctrl_s2_r  <= {CW{1'b0}};
         stab_cnt_r <= 16'd0;
      end else begin
         ctrl_s1_r <= ctrl_raw_s;
         ctrl_s2_r <= ctrl_s1_r;
         if (ctrl_s1_r != ctrl_s2_r)  stab_cnt_r <= 16'd0;
         else if (stab_cnt_r != DB_LIM) stab_cnt_r <= stab_cnt_r + 16'd1;
         else                         stab_cnt_r <= stab_cnt_r;
      end
   end

   // Effective control registers, loaded once per debounced change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_eff_r   <= {SEL_W{1'b0}};
         mode_eff_r  <= 2'b00;
         slice_eff_r <= 2'b00;
      end else if (load_s) begin
         sel_eff_r   <= sel_new_s;
         mode_eff_r  <= ctrl_s2_r[3:2];
         slice_eff_r <= ctrl_s2_r[1:0];
      end else begin
         sel_eff_r   <= sel_eff_r;
         mode_eff_r  <= mode_eff_r;
         slice_eff_r <= slice_eff_r;
      end
   end

   // Trigger synchroniser plus previous-value flop for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_s1_r   <= 1'b0;
         trig_s2_r   <= 1'b0;
         trig_prev_r <= 1'b0;
      end else begin
         trig_s1_r   <= trig_i;
         trig_s2_r   <= trig_s1_r;
         trig_prev_r <= trig_s2_r;
      end
   end

   // Per-channel change flags, selected word, mask and select-digit widening.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         chg_s[i] = (probe_i[i*DATA_W +: DATA_W] != prev_all_r[i*DATA_W +: DATA_W]);
      end
      sel_word_s = probe_i[int'(sel_idx_s)*DATA_W +: DATA_W];
      for (int i = 0; i < LED_W; i++) begin
         if (i < MASK_W) mask_led_s[i] = mask_r[i % MASK_W];
         else            mask_led_s[i] = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
         if (b < SEL_W) sel_nib_s[b] = sel_eff_r[b % SEL_W];
         else           sel_nib_s[b] = 1'b0;
      end
   end

   // LED source mux by effective mode.
   always_comb begin
      case (mode_eff_r)
         2'b00:   led_next_s = slice_of(sel_word_s, slice_eff_r);
         2'b01:   led_next_s = slice_of(hold_r, slice_eff_r);
         2'b10:   led_next_s = cnt_r;
         2'b11:   led_next_s = mask_led_s;
         default: led_next_s = {LED_W{1'b0}};
      endcase
   end

   // Probe history, hold capture, change counter and sticky mask (active in every mode).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_all_r <= {(CHANNELS*DATA_W){1'b0}};
         hold_r     <= {DATA_W{1'b0}};
         cnt_r      <= {LED_W{1'b0}};
         mask_r     <= {MASK_W{1'b0}};
      end else begin
         prev_all_r <= probe_i;
         if (trig_edge_s) hold_r <= sel_word_s;
         else             hold_r <= hold_r;
         // Clears take priority over counting in the same cycle.
         if (trig_edge_s || sel_upd_s)                         cnt_r <= {LED_W{1'b0}};
         else if (chg_s[sel_idx_s] && (cnt_r != {LED_W{1'b1}})) cnt_r <= cnt_r + LED_W'(1);
         else                                                  cnt_r <= cnt_r;
         if (trig_edge_s) mask_r <= {MASK_W{1'b0}};
         else             mask_r <= mask_r | chg_s[MASK_W-1:0];
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led      <= {LED_W{1'b0}};
         segdisp0 <= 7'b0000000;
         segdisp1 <= 7'b0000000;
      end else begin
         led      <= led_next_s;
         segdisp0 <= hex7(sel_nib_s);
         segdisp1 <= hex7({2'b00, mode_eff_r});
      end
   end

endmodule
